// File: rtl/emu_clk_rst_seq.sv
// Clock-enable and reset sequencer: staggered power-on release of NUM_DOM reset
// domains, per-domain clock-enable dividers and acknowledged runtime domain resets.
module emu_clk_rst_seq #(
  parameter int unsigned NUM_DOM     = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned DIV_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_DOM*DIV_W-1:0] div_ratio,
  input  logic [NUM_DOM-1:0]       rst_req,
  output logic [NUM_DOM-1:0]       hresetn,
  output logic [NUM_DOM-1:0]       clk_en,
  output logic [NUM_DOM-1:0]       rst_ack,
  output logic                     init_done
);

  localparam int unsigned LAST_REL = HOLD_CYCLES + (NUM_DOM - 1) * STAGGER;
  localparam int unsigned SEQ_W    = $clog2(LAST_REL + 2);
  localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {ST_RST, ST_SEQ, ST_RUN} gstate_t;
  typedef enum logic {D_IDLE, D_HOLD} dstate_t;

  gstate_t             state_q, state_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  dstate_t             dom_q  [NUM_DOM];
  dstate_t             dom_d  [NUM_DOM];
  logic [HOLD_W-1:0]   hold_q [NUM_DOM];
  logic [HOLD_W-1:0]   hold_d [NUM_DOM];
  logic [DIV_W-1:0]    div_q  [NUM_DOM];
  logic [DIV_W-1:0]    div_d  [NUM_DOM];
  logic [NUM_DOM-1:0]  req_prev_q;
  logic [NUM_DOM-1:0]  req_rise;
  logic [NUM_DOM-1:0]  hresetn_q, hresetn_d;
  logic [NUM_DOM-1:0]  clk_en_q, clk_en_d;
  logic [NUM_DOM-1:0]  rst_ack_q, rst_ack_d;
  logic                init_done_q, init_done_d;

  assign req_rise = rst_req & ~req_prev_q;

  always_comb begin
    logic [DIV_W-1:0] r;
    int unsigned      rel;
    state_d     = state_q;
    seq_d       = seq_q;
    dom_d       = dom_q;
    hold_d      = hold_q;
    div_d       = div_q;
    hresetn_d   = hresetn_q;
    clk_en_d    = '0;
    rst_ack_d   = '0;
    init_done_d = init_done_q;
    r           = '0;
    rel         = 0;

    if (state_q != ST_RUN) begin
      // Releases are decoded from the next count so each hresetn rises exactly on its cycle.
      seq_d   = seq_q + SEQ_W'(1);
      state_d = ST_SEQ;
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        rel          = HOLD_CYCLES + i * STAGGER;
        hresetn_d[i] = (32'(seq_d) >= rel);
      end
      if (seq_d == SEQ_W'(LAST_REL + 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        if (dom_q[i] == D_IDLE) begin
          if (req_rise[i]) begin
            dom_d[i]     = D_HOLD;
            hold_d[i]    = '0;
            hresetn_d[i] = 1'b0;
          end
        end else if (hold_q[i] == HOLD_W'(HOLD_CYCLES - 1)) begin
          dom_d[i]     = D_IDLE;
          hresetn_d[i] = 1'b1;
          rst_ack_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + HOLD_W'(1);
        end
      end
    end

    // Divider restarts at 0 on the first released cycle and wraps on every pulse.
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      r        = div_ratio[i*DIV_W +: DIV_W];
      div_d[i] = (hresetn_d[i] && hresetn_q[i]) ?
                 (clk_en_q[i] ? '0 : div_q[i] + DIV_W'(1)) : '0;
      clk_en_d[i] = hresetn_d[i] &&
                    ((r <= DIV_W'(1)) || (div_d[i] >= r - DIV_W'(1)));
    end
  end

  always_ff @(posedge clk) begin
    req_prev_q <= rst_req;
    if (reset) begin
      state_q     <= ST_RST;
      seq_q       <= '0;
      hresetn_q   <= '0;
      clk_en_q    <= '0;
      rst_ack_q   <= '0;
      init_done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        dom_q[i]  <= D_IDLE;
        hold_q[i] <= '0;
        div_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      hresetn_q   <= hresetn_d;
      clk_en_q    <= clk_en_d;
      rst_ack_q   <= rst_ack_d;
      init_done_q <= init_done_d;
      dom_q       <= dom_d;
      hold_q      <= hold_d;
      div_q       <= div_d;
    end
  end

  assign hresetn   = hresetn_q;
  assign clk_en    = clk_en_q;
  assign rst_ack   = rst_ack_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_emu_clk_rst_seq.sv
// Bench for emu_clk_rst_seq: cycle-indexed reference model compared every cycle,
// plus directed literal checks on the default instance and a minimal-parameter instance.
module tb_emu_clk_rst_seq;

  localparam int N    = 4;
  localparam int H    = 16;
  localparam int S    = 4;
  localparam int W    = 8;
  localparam int LAST = H + (N - 1) * S;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] div_ratio = '0;
  logic [N-1:0]   rst_req = '0;
  logic [N-1:0]   hresetn, clk_en, rst_ack;
  logic           init_done;
  logic           req_b = 1'b0;
  logic           h_b, en_b, ack_b, init_b;

  int tests = 0;
  int fails = 0;
  int dcyc  = 0;

  always #5 clk = ~clk;

  emu_clk_rst_seq #(.NUM_DOM(N), .HOLD_CYCLES(H), .STAGGER(S), .DIV_W(W)) dut (
    .clk(clk), .reset(reset), .div_ratio(div_ratio), .rst_req(rst_req),
    .hresetn(hresetn), .clk_en(clk_en), .rst_ack(rst_ack), .init_done(init_done)
  );

  emu_clk_rst_seq #(.NUM_DOM(1), .HOLD_CYCLES(1), .STAGGER(0), .DIV_W(8)) dut_b (
    .clk(clk), .reset(reset), .div_ratio(8'd0), .rst_req(req_b),
    .hresetn(h_b), .clk_en(en_b), .rst_ack(ack_b), .init_done(init_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: outputs derived from the cycle index since reset release.
  int         mc = 0;
  bit         m_started = 0;
  int         ph    [N];
  int         rprev [N];
  int         lo    [N];
  int         ackat [N];
  logic [N-1:0] prevq;

  function automatic bit exp_h(input int i, input int idx);
    return (idx >= H + i * S) && !(idx >= lo[i] && idx < ackat[i]);
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] eh, ee, ea;
    for (int i = 0; i < N; i++) begin
      eh[i] = exp_h(i, mc);
      ee[i] = eh[i] && (rprev[i] <= 1 || ph[i] >= rprev[i] - 1);
      ea[i] = (mc == ackat[i]);
    end
    if (m_started) begin
      check($sformatf("model hresetn c%0d", mc), 32'(hresetn), 32'(eh));
      check($sformatf("model clk_en c%0d", mc), 32'(clk_en), 32'(ee));
      check($sformatf("model rst_ack c%0d", mc), 32'(rst_ack), 32'(ea));
      check($sformatf("model init_done c%0d", mc), 32'(init_done), 32'(mc >= LAST + 1));
    end
    if (reset) begin
      m_started = 1;
      mc = 0;
      prevq = rst_req;
      for (int i = 0; i < N; i++) begin
        ph[i] = 0; lo[i] = -1; ackat[i] = -1;
        rprev[i] = int'(div_ratio[i*W +: W]);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rst_req[i] && !prevq[i] && mc >= LAST + 1 && mc >= ackat[i]) begin
          lo[i]    = mc + 1;
          ackat[i] = mc + H + 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        ph[i]    = (exp_h(i, mc) && exp_h(i, mc + 1)) ? (ee[i] ? 0 : ph[i] + 1) : 0;
        rprev[i] = int'(div_ratio[i*W +: W]);
      end
      prevq = rst_req;
      mc++;
    end
  end

  task automatic step();
    @(posedge clk); #1; dcyc++;
  endtask

  task automatic goto(input int c);
    while (dcyc < c) step();
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
    dcyc = 0;
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  initial begin
    // Power-on with all ratios 0; an edge during SEQ must be discarded.
    hold_reset(3);
    goto(10); rst_req[1] = 1'b1;
    goto(12); rst_req[1] = 1'b0;
    at_neg(15); check("p1 h c15", 32'(hresetn), 32'h0);
    at_neg(16); check("p1 h c16", 32'(hresetn), 32'h1); check("p1 en c16", 32'(clk_en), 32'h1);
    at_neg(20); check("p1 h c20", 32'(hresetn), 32'h3); check("p1 en c20", 32'(clk_en), 32'h3);
    at_neg(24); check("p1 h c24", 32'(hresetn), 32'h7);
    at_neg(28); check("p1 h c28", 32'(hresetn), 32'hf); check("p1 init c28", 32'(init_done), 32'h0);
    at_neg(29); check("p1 init c29", 32'(init_done), 32'h1);

    // Reset pulsed in cycle 40.
    goto(40); hold_reset(1);
    at_neg(0);
    check("rst h", 32'(hresetn), 32'h0); check("rst en", 32'(clk_en), 32'h0);
    check("rst ack", 32'(rst_ack), 32'h0); check("rst init", 32'(init_done), 32'h0);

    // Ratios: dom0=3, dom1=2, dom2=4, dom3=1.
    div_ratio = {8'd1, 8'd4, 8'd2, 8'd3};
    at_neg(16); check("p2 h c16", 32'(hresetn), 32'h1);
    at_neg(18); check("div en0 c18", 32'(clk_en[0]), 32'h1);
    at_neg(19); check("div en0 c19", 32'(clk_en[0]), 32'h0);
    at_neg(21); check("div en c21", 32'(clk_en), 32'h3);
    at_neg(24); check("div en0 c24", 32'(clk_en[0]), 32'h1);
    goto(26); div_ratio[7:0] = 8'd5;
    at_neg(27); check("div5 en0 c27", 32'(clk_en[0]), 32'h0);
    at_neg(28); check("div5 en0 c28", 32'(clk_en[0]), 32'h0);
    at_neg(29); check("div5 en0 c29", 32'(clk_en[0]), 32'h1);
    at_neg(34); check("div5 en0 c34", 32'(clk_en[0]), 32'h1);

    // Runtime request on domain 2.
    goto(100); rst_req[2] = 1'b1;
    at_neg(100); check("rq2 h c100", 32'(hresetn), 32'hf);
    at_neg(101); check("rq2 h c101", 32'(hresetn), 32'hb);
    goto(105); rst_req[2] = 1'b0;
    at_neg(116); check("rq2 h c116", 32'(hresetn), 32'hb);
    at_neg(117); check("rq2 h c117", 32'(hresetn), 32'hf); check("rq2 ack c117", 32'(rst_ack), 32'h4);
    at_neg(118); check("rq2 ack c118", 32'(rst_ack), 32'h0);

    // Simultaneous requests on 0 and 3, with a second edge on 0 during HOLD.
    goto(130); rst_req[0] = 1'b1; rst_req[3] = 1'b1;
    goto(135); rst_req[0] = 1'b0;
    goto(140); rst_req[0] = 1'b1;
    at_neg(147); check("sim ack c147", 32'(rst_ack), 32'h9); check("sim h c147", 32'(hresetn), 32'hf);
    goto(150); rst_req[0] = 1'b0; rst_req[3] = 1'b0;
    at_neg(157); check("ovl ack c157", 32'(rst_ack), 32'h0); check("ovl h c157", 32'(hresetn), 32'hf);

    // Level held high gives exactly one reset.
    goto(160); rst_req[1] = 1'b1;
    at_neg(177); check("lvl ack c177", 32'(rst_ack), 32'h2);
    at_neg(200); check("lvl h c200", 32'(hresetn), 32'hf);
    goto(210);

    // Restart: edge at cycle 28 (SEQ) discarded, edge at 29 (RUN entry) serviced.
    rst_req = '0;
    hold_reset(2);
    at_neg(0); check("b h c0", 32'(h_b), 32'h0); check("b init c0", 32'(init_b), 32'h0);
    at_neg(1); check("b h c1", 32'(h_b), 32'h1); check("b en c1", 32'(en_b), 32'h1);
    check("b init c1", 32'(init_b), 32'h0);
    at_neg(2); check("b init c2", 32'(init_b), 32'h1);
    goto(5); req_b = 1'b1;
    at_neg(6); check("b h c6", 32'(h_b), 32'h0); check("b en c6", 32'(en_b), 32'h0);
    at_neg(7); check("b h c7", 32'(h_b), 32'h1); check("b ack c7", 32'(ack_b), 32'h1);
    at_neg(8); check("b ack c8", 32'(ack_b), 32'h0);
    goto(9); req_b = 1'b0;
    goto(28); rst_req[3] = 1'b1;
    goto(29); rst_req[1] = 1'b1;
    at_neg(29); check("entry init c29", 32'(init_done), 32'h1);
    at_neg(30); check("entry h c30", 32'(hresetn), 32'hd);
    at_neg(46); check("entry ack c46", 32'(rst_ack), 32'h2); check("entry h c46", 32'(hresetn), 32'hf);
    goto(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/emu_clk_rst_seq.md
# emu_clk_rst_seq

Parametrised, synthesizable clock-enable and reset sequencer for the emulator-side HDL top. It replaces free-running behavioural clock/reset generation with a cycle-deterministic power-on release sequence across NUM_DOM reset domains, each with its own clock-enable divider. It also accepts per-domain runtime reset requests from the HVL side and acknowledges them. Each hresetn output drives the HRESETn of one AHB interface/DUT domain.

## Interface

Parameters:
- NUM_DOM, 4, number of reset/clock-enable domains (1..16)
- HOLD_CYCLES, 16, cycles a domain's reset is held asserted (>=1)
- STAGGER, 4, cycles between successive domain releases at power-on (>=0; 0 releases all domains together)
- DIV_W, 8, width of each divider ratio field

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- div_ratio  in  NUM_DOM*DIV_W  per-domain clock-enable ratio; field i is bits [i*DIV_W +: DIV_W]
- rst_req  in  NUM_DOM  per-domain runtime reset request; acts on the rising edge
- hresetn  out  NUM_DOM  per-domain active-low reset
- clk_en  out  NUM_DOM  per-domain clock-enable pulse
- rst_ack  out  NUM_DOM  one-cycle pulse when a requested domain reset completes
- init_done  out  1  power-on sequence complete

## Operation

- Global FSM states:
  - RST: entered while reset=1.
  - SEQ: entered on the first cycle with reset=0.
  - RUN: entered after the last domain is released.
- Reset values while reset=1 and on the following edge:
  - hresetn=0, clk_en=0, rst_ack=0, init_done=0.
  - All counters cleared.
  - rst_req edge detector cleared, with its history register loaded from rst_req.
- SEQ:
  - A free-running sequence counter starts at 0 in the first cycle after reset deasserts (cycle 0).
  - hresetn[i] first reads 1 in cycle HOLD_CYCLES + i*STAGGER.
  - init_done first reads 1 in cycle HOLD_CYCLES + (NUM_DOM-1)*STAGGER + 1, when the FSM moves to RUN.
  - All rst_req edges are discarded.
- RUN:
  - Each domain has an independent sub-FSM with states IDLE and HOLD.
  - A rising edge of rst_req[i] (high in cycle t, low in t-1) seen while domain i is IDLE puts the domain in HOLD.
  - hresetn[i]=0 in cycles t+1 .. t+HOLD_CYCLES.
  - hresetn[i]=1 in cycle t+HOLD_CYCLES+1, and rst_ack[i]=1 in that same cycle only.
  - Edges arriving while domain i is in HOLD are ignored, and no ack is generated for them.
  - Simultaneous requests on several domains are serviced in parallel and independently.
  - init_done stays 1 through runtime domain resets.
- Clock enable, per domain:
  - Divider counter cnt[i] is forced to 0 while hresetn[i]=0.
  - Ratio field r = 0 or 1: clk_en[i]=1 every cycle hresetn[i]=1.
  - Ratio r >= 2: clk_en[i]=1 when cnt[i] >= r-1, and cnt wraps to 0 on that cycle. Otherwise cnt increments.
  - The first release cycle has cnt=0, so the first pulse comes r-1 cycles after release.
  - A ratio change takes effect immediately. If the current cnt >= new r-1, the domain pulses and wraps on the next cycle.
  - clk_en[i] is always 0 while hresetn[i]=0.
- Counter widths:
  - Sequence counter: $clog2(HOLD_CYCLES+(NUM_DOM-1)*STAGGER+2) bits; saturates in RUN, no wrap.
  - Hold counters: $clog2(HOLD_CYCLES+1) bits.
  - Divider counters: DIV_W bits.

## Timing

- All outputs are registered. There are no combinational paths from inputs to outputs.
- reset asserted mid-operation, whether in SEQ, HOLD or RUN, returns every output to its reset value on the next cycle. The full SEQ restarts when reset deasserts.
- With STAGGER=0, all hresetn bits rise in the same cycle, HOLD_CYCLES.
- rst_req held high continuously produces exactly one reset. It must go low and rise again to retrigger.
- A rst_req rising edge on the exact cycle the FSM enters RUN is serviced.

## Test plan

- Power-on, defaults, div_ratio all 0:
  - hresetn[0..3] rise in cycles 16/20/24/28.
  - clk_en[i] goes high in the same cycle as its domain's release.
  - init_done rises in cycle 29.
- Divider, ratio field 0 = 3, released in cycle 16:
  - clk_en[0] pulses in cycles 18, 21, 24, …
  - Changing the ratio to 5 while cnt=1 gives the next pulse 3 cycles later.
- Runtime request: rst_req[2] rises in cycle 100 (in RUN):
  - hresetn[2]=0 in cycles 101..116.
  - hresetn[2]=1 and rst_ack[2]=1 in cycle 117; other domains are unaffected.
- Simultaneous and overlapping requests:
  - rst_req[0] and rst_req[3] rise in the same cycle: both domains ack in the same cycle.
  - A second edge on rst_req[0] during its HOLD produces no extra ack.
- Discard and mid-operation reset:
  - A rst_req edge at cycle 10 (SEQ) is ignored.
  - reset pulsed in cycle 40: all outputs are 0 in cycle 41, and the sequence replays starting 16 cycles after deassertion.
- Parameter sweep NUM_DOM=1, HOLD_CYCLES=1, STAGGER=0:
  - hresetn[0] rises in cycle 1 and init_done in cycle 2.
  - A request gives exactly 1 cycle low, then an ack.
